data_mem_responder: RTL and testbench

- Data-memory responder that sits on the far end of the processor's data port (DataAddr/DataOut/ReadData/WriteData in, DataIn/DataDone out).
- Serves single-word loads and stores from an internal word array with a programmable number of wait states.
- Drives DataDone low while an access is in progress, which stalls the processor's Memory1 stage.
- Used in the top-level system and as the memory model in processor benches.

---
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: single-word loads/stores with programmable wait states.
// DataDone drops while an access is outstanding so the Memory1 stage stalls.
module data_mem_responder #(
    parameter int WORD_SIZE   = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 Busy,
    output logic                 AddrErr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [WORD_SIZE:0] DEPTH_LIM = (WORD_SIZE + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic wr_q, wr_d;

    logic req;
    logic acc_go;
    logic acc_wr;
    logic [WORD_SIZE-1:0] acc_addr;
    logic [WORD_SIZE-1:0] acc_wdata;
    logic acc_ok;
    logic [AW-1:0] acc_idx;
    logic [WORD_SIZE-1:0] rdata;
    logic mem_we;

    logic [WORD_SIZE-1:0] data_in_d;
    logic done_d;
    logic busy_d;
    logic err_d;

    // Contents survive Reset and start undefined.
    logic [WORD_SIZE-1:0] mem [DEPTH];

    assign req = ReadData | WriteData;

    // Next-state: accept in IDLE/DONE, count down in WAIT, access at the last edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        acc_go    = 1'b0;
        acc_wr    = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req) begin
                    addr_d  = DataAddr;
                    wdata_d = DataOut;
                    wr_d    = WriteData;
                    if (NO_WAIT) begin
                        acc_go    = 1'b1;
                        acc_wr    = WriteData;
                        acc_addr  = DataAddr;
                        acc_wdata = DataOut;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc_go  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Range check on the full address; only the low bits index the array.
    always_comb begin
        acc_ok  = {1'b0, acc_addr} < DEPTH_LIM;
        acc_idx = acc_addr[AW-1:0];
        rdata   = '0;
        if (acc_ok) begin
            rdata = mem[acc_idx];
        end
        mem_we = acc_go & acc_wr & acc_ok & ~Reset;
    end

    // Registered output values for the cycle after this edge.
    always_comb begin
        done_d    = (state_d != WAIT);
        busy_d    = (state_d == WAIT);
        data_in_d = '0;
        if (acc_go && !acc_wr) begin
            data_in_d = rdata;
        end
        err_d = AddrErr | (acc_go & ~acc_ok);
    end

    // State, latched request and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            DataIn   <= '0;
            DataDone <= 1'b1;
            Busy     <= 1'b0;
            AddrErr  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            DataIn   <= data_in_d;
            DataDone <= done_d;
            Busy     <= busy_d;
            AddrErr  <= err_d;
        end
    end

    // Array write; an access abandoned by Reset never lands.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with wait states,
// one with zero wait states, both against a simple array model.
module tb_data_mem_responder;

    typedef struct {
        int          acc;
        int          due;
        logic [15:0] data;
        logic        oob;
    } item_t;

    logic clk;
    int   cyc;
    int   n_tot;
    int   n_pass;
    bit   gdone [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        n_tot  = 0;
        n_pass = 0;
    end

    task automatic chk(input int g, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tot = n_tot + 1;
        if (act !== exp)
            $display("FAIL dut%0d %s at cycle %0d: got %h expected %h",
                     g, nm, cyc, act, exp);
        else
            n_pass = n_pass + 1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int W = (g == 0) ? 2 : 0;

        logic        rst;
        logic [15:0] addr;
        logic [15:0] dout;
        logic        rd;
        logic        wr;
        logic [15:0] din;
        logic        done;
        logic        busy;
        logic        err;

        logic [15:0] mem_m [256];
        item_t       q [$];
        item_t       mit;
        logic        err_m;
        bit          started;
        int          op;
        int          gap;
        logic [15:0] ra;

        data_mem_responder #(
            .WORD_SIZE(16),
            .DEPTH(256),
            .WAIT_CYCLES(W)
        ) u_dut (
            .Clock(clk),
            .Reset(rst),
            .DataAddr(addr),
            .DataOut(dout),
            .ReadData(rd),
            .WriteData(wr),
            .DataIn(din),
            .DataDone(done),
            .Busy(busy),
            .AddrErr(err)
        );

        // Drive at a negedge, hold until the DONE cycle's negedge.
        task automatic issue(input logic [15:0] a, input logic [15:0] d,
                             input logic r, input logic w);
            item_t it;
            it.oob = (a >= 16'd256);
            it.acc = cyc + 1;
            it.due = cyc + 1 + W;
            if (w) begin
                it.data = 16'h0000;
                if (!it.oob) mem_m[a[7:0]] = d;
            end else begin
                it.data = it.oob ? 16'h0000 : mem_m[a[7:0]];
            end
            q.push_back(it);
            addr = a;
            dout = d;
            rd   = r;
            wr   = w;
            repeat (W + 1) @(negedge clk);
        endtask

        task automatic idle(input int n);
            rd = 1'b0;
            wr = 1'b0;
            repeat (n) @(negedge clk);
        endtask

        initial begin
            started = 1'b0;
            err_m   = 1'b0;
            rst     = 1'b1;
            rd      = 1'b0;
            wr      = 1'b0;
            addr    = 16'h0;
            dout    = 16'h0;
            repeat (2) @(negedge clk);
            rst     = 1'b0;
            started = 1'b1;
            idle(5);
            for (int i = 0; i < 256; i++)
                issue(16'(i), 16'($urandom), 1'b0, 1'b1);
            idle(1);
            issue(16'h0010, 16'hBEEF, 1'b0, 1'b1);
            idle(1);
            issue(16'h0010, 16'h0000, 1'b1, 1'b0);
            idle(1);
            issue(16'h0003, 16'h1111, 1'b0, 1'b1);
            issue(16'h0004, 16'h2222, 1'b0, 1'b1);
            issue(16'h0003, 16'h0000, 1'b1, 1'b0);
            issue(16'h0004, 16'h0000, 1'b1, 1'b0);
            idle(2);
            issue(16'h0005, 16'h00A5, 1'b1, 1'b1);
            issue(16'h0005, 16'h0000, 1'b1, 1'b0);
            idle(1);
            issue(16'h0100, 16'h0000, 1'b1, 1'b0);
            idle(3);
            for (int k = 0; k < 150; k++) begin
                op = $urandom_range(0, 2);
                if ($urandom_range(0, 15) == 0)
                    ra = 16'($urandom_range(256, 65535));
                else
                    ra = 16'($urandom_range(0, 255));
                issue(ra, 16'($urandom), op != 1, op != 0);
                gap = $urandom_range(0, 2);
                if (gap > 0) idle(gap);
            end
            idle(1);
            issue(16'h0008, 16'h0001, 1'b0, 1'b1);
            idle(1);
            if (W > 0) begin
                mit.oob  = 1'b0;
                mit.acc  = cyc + 1;
                mit.due  = cyc + 1 + W;
                mit.data = 16'h0000;
                q.push_back(mit);
                addr = 16'h0008;
                dout = 16'h7777;
                wr   = 1'b1;
                @(negedge clk);
            end
            rst = 1'b1;
            rd  = 1'b0;
            wr  = 1'b0;
            q.delete();
            err_m = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            idle(2);
            issue(16'h0008, 16'h0000, 1'b1, 1'b0);
            idle(4);
            gdone[g] = 1'b1;
        end

        initial begin
            wait (started);
            forever begin
                @(posedge clk);
                #1;
                if (q.size() > 0 && q[0].due == cyc) begin
                    mit = q.pop_front();
                    if (mit.oob) err_m = 1'b1;
                    chk(g, "done_ack", 32'(done), 32'd1);
                    chk(g, "done_data", 32'(din), 32'(mit.data));
                    chk(g, "done_busy", 32'(busy), 32'd0);
                    chk(g, "done_err", 32'(err), 32'(err_m));
                end else if (q.size() > 0 && cyc >= q[0].acc) begin
                    chk(g, "wait_ack", 32'(done), 32'd0);
                    chk(g, "wait_busy", 32'(busy), 32'd1);
                end else begin
                    chk(g, "idle_ack", 32'(done), 32'd1);
                    chk(g, "idle_data", 32'(din), 32'd0);
                    chk(g, "idle_busy", 32'(busy), 32'd0);
                    chk(g, "idle_err", 32'(err), 32'(err_m));
                end
            end
        end
    end

    initial begin
        fork
            wait (gdone[0] && gdone[1]);
            begin
                #2_000_000;
                n_tot = n_tot + 1;
                $display("FAIL timeout: stimulus did not complete");
            end
        join_any
        disable fork;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
